// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID->EX operand stage with forwarding, load-use bubbles and handshake
module alu_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [WIDTH-1:0]  imm,
    input  logic              is_rtype,
    input  logic [2:0]        funct3,
    input  logic              funct7_5_in,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [WIDTH-1:0]  exmem_result,
    input  logic              exmem_is_load,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [WIDTH-1:0]  memwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  rs_1,
    output logic [WIDTH-1:0]  rs_2,
    output logic              En,
    output logic              funct7_5,
    output logic [REG_AW-1:0] rd_out
);

    logic             hazard;
    logic             capture;
    logic             slot_free;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2_reg;
    logic [WIDTH-1:0] op2;

    // x0 is hard zero; the younger EX/MEM result wins over MEM/WB
    function automatic logic [WIDTH-1:0] resolve(input logic [REG_AW-1:0] addr,
                                                 input logic [WIDTH-1:0]  rf_data);
        if (addr == '0)
            return '0;
        else if (exmem_wr && (exmem_rd == addr))
            return exmem_result;
        else if (memwb_wr && (memwb_rd == addr))
            return memwb_result;
        else
            return rf_data;
    endfunction

    // operand resolution, load-use detection and acceptance
    always_comb begin
        op1       = resolve(rs1_addr, rs1_data);
        op2_reg   = resolve(rs2_addr, rs2_data);
        op2       = is_rtype ? op2_reg : imm;
        hazard    = exmem_is_load && exmem_wr && (exmem_rd != '0) &&
                    ((rs1_addr == exmem_rd) || (is_rtype && (rs2_addr == exmem_rd)));
        slot_free = !out_valid || out_ready;
        in_ready  = !RST && slot_free && !hazard;
        capture   = in_valid && in_ready && !flush;
    end

    // output register: reset/flush clear, capture loads, consumption without capture leaves a bubble
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            out_valid <= 1'b0;
            rs_1      <= '0;
            rs_2      <= '0;
            En        <= 1'b0;
            funct7_5  <= 1'b0;
            rd_out    <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            rs_1      <= op1;
            rs_2      <= op2;
            En        <= (funct3 == 3'b000);
            funct7_5  <= is_rtype && funct7_5_in;
            rd_out    <= rd_addr;
        end else if (slot_free) begin
            out_valid <= 1'b0;
            En        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage with a behavioural model
module tb_alu_operand_stage;

    logic        CLK, RST, flush, in_valid, in_ready, is_rtype, funct7_5_in;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, exmem_result, memwb_result, rs_1, rs_2;
    logic [2:0]  funct3;
    logic        exmem_wr, exmem_is_load, memwb_wr, out_valid, out_ready, En, funct7_5;

    alu_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .is_rtype(is_rtype),
        .funct3(funct3), .funct7_5_in(funct7_5_in),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .exmem_is_load(exmem_is_load),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs_1(rs_1), .rs_2(rs_2), .En(En), .funct7_5(funct7_5), .rd_out(rd_out)
    );

    typedef struct packed {
        logic        rst, fl, iv, ordy, rt, f75, exw, exld, mww;
        logic [4:0]  a1, a2, rd, exrd, mwrd;
        logic [31:0] d1, d2, im, exres, mwres;
        logic [2:0]  f3;
    } stim_t;

    typedef struct packed {
        logic [31:0] r1, r2;
        logic        en, f7;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 0;
    bit   zero_pending = 0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // reference model: read-after-write resolution as a priority of newest producer first
    function automatic logic [31:0] model_src(input stim_t s, input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (s.exw && s.exrd == a) return s.exres;
        if (s.mww && s.mwrd == a) return s.mwres;
        return rf;
    endfunction

    function automatic bit model_hazard(input stim_t s);
        bit reads;
        reads = (s.a1 == s.exrd) || (s.rt && s.a2 == s.exrd);
        return s.exld && s.exw && s.exrd != 0 && reads;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ordy = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // one cycle of stimulus; acceptance and expected in_ready come from the model
    task automatic step(input stim_t s);
        exp_t e;
        bit   exp_rdy;
        @(posedge CLK);
        #1;
        RST = s.rst; flush = s.fl; in_valid = s.iv; out_ready = s.ordy;
        rs1_addr = s.a1; rs2_addr = s.a2; rd_addr = s.rd;
        rs1_data = s.d1; rs2_data = s.d2; imm = s.im; is_rtype = s.rt;
        funct3 = s.f3; funct7_5_in = s.f75;
        exmem_wr = s.exw; exmem_rd = s.exrd; exmem_result = s.exres; exmem_is_load = s.exld;
        memwb_wr = s.mww; memwb_rd = s.mwrd; memwb_result = s.mwres;
        #7;
        exp_rdy = !s.rst && (q.size() == 0 || s.ordy) && !model_hazard(s);
        check("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        if (s.rst || s.fl) begin
            q.delete();
            zero_pending = 1;
        end else if (s.iv && exp_rdy) begin
            e.r1 = model_src(s, s.a1, s.d1);
            e.r2 = s.rt ? model_src(s, s.a2, s.d2) : s.im;
            e.en = (s.f3 == 0);
            e.f7 = s.rt && s.f75;
            e.rd = s.rd;
            q.push_back(e);
        end
    endtask

    // monitor: valid must track the scoreboard; presented data must equal its head until consumed
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                check("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
                if (!out_valid)
                    check("bubble_en", {127'd0, En}, 128'd0);
                if (zero_pending) begin
                    check("cleared", {rs_1, rs_2, En, funct7_5, rd_out, out_valid},
                                     {32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0});
                    zero_pending = 0;
                end
                if (out_valid && q.size() != 0) begin
                    check("operands", {rs_1, rs_2, En, funct7_5, rd_out},
                                      {q[0].r1, q[0].r2, q[0].en, q[0].f7, q[0].rd});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        stim_t s, ins;
        RST = 1; flush = 0; in_valid = 0; out_ready = 1;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rs1_data = 0; rs2_data = 0; imm = 0;
        is_rtype = 0; funct3 = 0; funct7_5_in = 0; exmem_wr = 0; exmem_rd = 0;
        exmem_result = 0; exmem_is_load = 0; memwb_wr = 0; memwb_rd = 0; memwb_result = 0;

        s = idle(); s.rst = 1; s.iv = 1;
        step(s);
        mon_en = 1;
        step(s);

        // ADD x3 = x1 + x2
        s = idle(); s.iv = 1; s.rt = 1; s.a1 = 1; s.a2 = 2; s.rd = 3; s.d1 = 5; s.d2 = 7;
        step(s);
        // SUB with both forwarding sources on x1, x2 is x0 with EX/MEM rd=0
        s = idle(); s.iv = 1; s.rt = 1; s.f75 = 1; s.a1 = 1; s.a2 = 0; s.rd = 5;
        s.d1 = 32'h30; s.d2 = 32'h99; s.exw = 1; s.exrd = 1; s.exres = 32'h10;
        s.mww = 1; s.mwrd = 1; s.mwres = 32'h20;
        step(s);
        s.exrd = 0; s.a1 = 0;
        step(s);
        // ADDI with imm all ones, bit 30 set, rs2 matching EX/MEM
        s = idle(); s.iv = 1; s.a1 = 6; s.a2 = 7; s.rd = 8; s.d1 = 32'h1234; s.im = 32'hFFFF_FFFF;
        s.f75 = 1; s.exw = 1; s.exrd = 7; s.exres = 32'hDEAD;
        step(s);
        // load-use on x4, then load clears
        s = idle(); s.iv = 1; s.rt = 1; s.a1 = 4; s.a2 = 2; s.rd = 9; s.d1 = 11; s.d2 = 22;
        s.exw = 1; s.exld = 1; s.exrd = 4; s.exres = 32'h44;
        step(s);
        s.exld = 0; s.exw = 0;
        step(s);
        // backpressure three cycles, then release with a new instruction
        s = idle(); s.iv = 1; s.rt = 1; s.a1 = 2; s.a2 = 3; s.rd = 10; s.d1 = 1; s.d2 = 2; s.f3 = 3'b001;
        step(s);
        s.ordy = 0; s.d1 = 100; s.rd = 11;
        step(s); step(s); step(s);
        s.ordy = 1;
        step(s);
        // flush during hold, then reset mid-stream
        s.ordy = 0; s.rd = 12;
        step(s);
        s.fl = 1;
        step(s);
        s.fl = 0; s.ordy = 1;
        step(s);
        s.rst = 1;
        step(s);
        s.rst = 0;
        step(s);

        // randomized traffic with tight address range so forwarding and hazards collide often
        for (int i = 0; i < 3000; i++) begin
            ins.rst   = ($urandom_range(0, 99) < 2);
            ins.fl    = ($urandom_range(0, 99) < 5);
            ins.iv    = ($urandom_range(0, 99) < 80);
            ins.ordy  = ($urandom_range(0, 99) < 70);
            ins.rt    = $urandom_range(0, 1);
            ins.f75   = $urandom_range(0, 1);
            ins.exw   = $urandom_range(0, 1);
            ins.exld  = ($urandom_range(0, 99) < 25);
            ins.mww   = $urandom_range(0, 1);
            ins.a1    = 5'($urandom_range(0, 7));
            ins.a2    = 5'($urandom_range(0, 7));
            ins.rd    = 5'($urandom_range(0, 31));
            ins.exrd  = 5'($urandom_range(0, 7));
            ins.mwrd  = 5'($urandom_range(0, 7));
            ins.d1    = $urandom;
            ins.d2    = $urandom;
            ins.im    = $urandom;
            ins.exres = $urandom;
            ins.mwres = $urandom;
            ins.f3    = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'($urandom_range(0, 7));
            step(ins);
        end
        s = idle();
        step(s);
        step(s);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
